// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: definitions shared by the writeback stage and its load aligner.
//   - Reset and write-enable levels, the zero word, and register bus widths.
//   - RV32I load funct3 codes.
//   - Writeback FSM state encodings.
package wb_stage_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam int          RegNumLog2  = 5;
  localparam int          RegBus      = 32;
  localparam int          RegAddrBus  = RegNumLog2;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational load-data aligner.
// Ports:
//   funct3  - load funct3 (LB/LH/LW/LBU/LHU; undefined codes behave as LW)
//   byteoff - load address bits [1:0]
//   rdata   - raw memory word
//   adata   - aligned, sign- or zero-extended result
// The MEM stage also instantiates this block for its forwarding checks.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        byteoff,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] adata
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword; the halfword ignores byteoff[0].
  always_comb begin
    byte_s = rdata[{byteoff, 3'b000} +: 8];
    if (byteoff[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extend the selected field according to the load type.
  always_comb begin
    case (funct3)
      F3_LB:   adata = {{(DATA_W-8){byte_s[7]}}, byte_s};
      F3_LBU:  adata = {{(DATA_W-8){1'b0}}, byte_s};
      F3_LH:   adata = {{(DATA_W-16){half_s[15]}}, half_s};
      F3_LHU:  adata = {{(DATA_W-16){1'b0}}, half_s};
      F3_LW:   adata = rdata;
      default: adata = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: RV32I writeback stage, producer end of the register file write port.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   ex_valid/ex_ready            - handshake with the MEM stage
//   ex_wreg, ex_wd, ex_wdata     - write flag, rd, non-load result
//   ex_is_load, ex_ld_funct3,
//   ex_ld_byteoff                - load descriptor
//   mem_rvalid, mem_rdata        - load response (single-cycle pulse)
//   we, waddr, wdata             - registered register-file write port
//   busy                         - a load is outstanding
//   err_unexp                    - sticky: response arrived with no load pending
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_wreg,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic [2:0]        ex_ld_funct3,
  input  logic [1:0]        ex_ld_byteoff,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              err_unexp
);

  wb_state_e         state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              wreg_q, wreg_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        byteoff_q, byteoff_d;
  logic [DATA_W-1:0] aligned_s;

  load_align #(.DATA_W(DATA_W)) u_align (
    .funct3  (funct3_q),
    .byteoff (byteoff_q),
    .rdata   (mem_rdata),
    .adata   (aligned_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= WB_IDLE;
      we_q      <= 1'b0;
      waddr_q   <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      err_q     <= 1'b0;
      rd_q      <= {ADDR_W{1'b0}};
      wreg_q    <= 1'b0;
      funct3_q  <= 3'b000;
      byteoff_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      wreg_q    <= wreg_d;
      funct3_q  <= funct3_d;
      byteoff_q <= byteoff_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE: begin
        if (ex_valid && ex_is_load) begin
          state_d = WB_WAIT_LOAD;
        end else begin
          state_d = WB_IDLE;
        end
      end
      WB_WAIT_LOAD: begin
        if (mem_rvalid) begin
          state_d = WB_IDLE;
        end else begin
          state_d = WB_WAIT_LOAD;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // Write port, load capture and error flag; write address/data hold unless
  // a completion occurs, so only we pulses.
  always_comb begin
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rd_d      = rd_q;
    wreg_d    = wreg_q;
    funct3_d  = funct3_q;
    byteoff_d = byteoff_q;
    case (state_q)
      WB_IDLE: begin
        // A response with nothing outstanding is dropped but remembered,
        // even when a new load is accepted in the same cycle.
        if (mem_rvalid) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (ex_valid && ex_is_load) begin
          rd_d      = ex_wd;
          wreg_d    = ex_wreg;
          funct3_d  = ex_ld_funct3;
          byteoff_d = ex_ld_byteoff;
        end else if (ex_valid) begin
          we_d    = ex_wreg & (ex_wd != {ADDR_W{1'b0}});
          waddr_d = ex_wd;
          wdata_d = ex_wdata;
        end else begin
          we_d = 1'b0;
        end
      end
      WB_WAIT_LOAD: begin
        if (mem_rvalid) begin
          we_d    = wreg_q & (rd_q != {ADDR_W{1'b0}});
          waddr_d = rd_q;
          wdata_d = aligned_s;
        end else begin
          we_d = 1'b0;
        end
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    case (state_q)
      WB_IDLE: begin
        ex_ready = 1'b1;
        busy     = 1'b0;
      end
      WB_WAIT_LOAD: begin
        ex_ready = 1'b0;
        busy     = 1'b1;
      end
      default: begin
        ex_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign err_unexp = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_wreg;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata;
  logic        ex_is_load;
  logic [2:0]  ex_ld_funct3;
  logic [1:0]  ex_ld_byteoff;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        err_unexp;

  int vectors;
  int miscompares;

  wb_stage #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_wreg       (ex_wreg),
    .ex_wd         (ex_wd),
    .ex_wdata      (ex_wdata),
    .ex_is_load    (ex_is_load),
    .ex_ld_funct3  (ex_ld_funct3),
    .ex_ld_byteoff (ex_ld_byteoff),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .we            (we),
    .waddr         (waddr),
    .wdata         (wdata),
    .busy          (busy),
    .err_unexp     (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_op(input logic wreg, input logic [4:0] wd, input logic [31:0] d);
    ex_valid   = 1'b1;
    ex_is_load = 1'b0;
    ex_wreg    = wreg;
    ex_wd      = wd;
    ex_wdata   = d;
  endtask

  // Issue a load, answer after 'delay' busy cycles, then check the write.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                         input logic [4:0] wd, input logic [31:0] rdata, input int delay,
                         input logic exp_we, input logic [31:0] exp_data);
    ex_valid      = 1'b1;
    ex_is_load    = 1'b1;
    ex_wreg       = 1'b1;
    ex_wd         = wd;
    ex_ld_funct3  = f3;
    ex_ld_byteoff = off;
    tick();
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    chk({tag, " ready"}, {31'd0, ex_ready}, 32'd0);
    chk({tag, " no early we"}, {31'd0, we}, 32'd0);
    for (int i = 1; i < delay; i++) begin
      tick();
      chk({tag, " busy wait"}, {31'd0, busy}, 32'd1);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    chk({tag, " we"}, {31'd0, we}, {31'd0, exp_we});
    if (exp_we) begin
      chk({tag, " waddr"}, {27'd0, waddr}, {27'd0, wd});
      chk({tag, " wdata"}, wdata, exp_data);
    end
    chk({tag, " busy clr"}, {31'd0, busy}, 32'd0);
    chk({tag, " ready back"}, {31'd0, ex_ready}, 32'd1);
    tick();
    chk({tag, " we pulse"}, {31'd0, we}, 32'd0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    ex_valid      = 1'b0;
    ex_wreg       = 1'b0;
    ex_wd         = 5'd0;
    ex_wdata      = 32'd0;
    ex_is_load    = 1'b0;
    ex_ld_funct3  = 3'b000;
    ex_ld_byteoff = 2'b00;
    mem_rvalid    = 1'b0;
    mem_rdata     = 32'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    chk("rst we", {31'd0, we}, 32'd0);
    chk("rst waddr", {27'd0, waddr}, 32'd0);
    chk("rst wdata", wdata, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst err", {31'd0, err_unexp}, 32'd0);
    chk("rst ready", {31'd0, ex_ready}, 32'd1);

    // Simple non-load, latency 1, one-cycle pulse, data held.
    send_op(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    ex_valid = 1'b0;
    chk("alu we", {31'd0, we}, 32'd1);
    chk("alu waddr", {27'd0, waddr}, 32'd5);
    chk("alu wdata", wdata, 32'hDEADBEEF);
    tick();
    chk("alu we drop", {31'd0, we}, 32'd0);
    chk("alu wdata hold", wdata, 32'hDEADBEEF);

    // Load alignment cases.
    do_load("lb",   3'b000, 2'd2, 5'd6,  32'h12F45678, 3, 1'b1, 32'hFFFFFFF4);
    do_load("lbu",  3'b100, 2'd2, 5'd7,  32'h12F45678, 3, 1'b1, 32'h000000F4);
    do_load("lh",   3'b001, 2'd3, 5'd8,  32'h8001ABCD, 1, 1'b1, 32'hFFFF8001);
    do_load("lhu",  3'b101, 2'd0, 5'd9,  32'h8001ABCD, 2, 1'b1, 32'h0000ABCD);
    do_load("lw",   3'b010, 2'd1, 5'd10, 32'h8001ABCD, 1, 1'b1, 32'h8001ABCD);
    do_load("lb0",  3'b000, 2'd0, 5'd11, 32'h0000007F, 1, 1'b1, 32'h0000007F);
    do_load("f3_6", 3'b110, 2'd3, 5'd12, 32'h80C0FFEE, 1, 1'b1, 32'h80C0FFEE);

    // Writes to x0 never assert we.
    send_op(1'b1, 5'd0, 32'h00000001);
    tick();
    ex_valid = 1'b0;
    chk("x0 alu we", {31'd0, we}, 32'd0);
    do_load("x0 ld", 3'b010, 2'd0, 5'd0, 32'h11111111, 2, 1'b0, 32'd0);

    // Back-to-back non-loads x1..x4.
    for (int i = 1; i <= 4; i++) begin
      send_op(1'b1, 5'(i), 32'h100 + 32'(i));
      tick();
      chk("b2b we", {31'd0, we}, 32'd1);
      chk("b2b waddr", {27'd0, waddr}, 32'(i));
      chk("b2b wdata", wdata, 32'h100 + 32'(i));
    end
    ex_valid = 1'b0;
    tick();
    chk("b2b end", {31'd0, we}, 32'd0);

    // Load followed by a held non-load.
    ex_valid      = 1'b1;
    ex_is_load    = 1'b1;
    ex_wreg       = 1'b1;
    ex_wd         = 5'd20;
    ex_ld_funct3  = 3'b010;
    ex_ld_byteoff = 2'b00;
    tick();
    send_op(1'b1, 5'd21, 32'hCAFEF00D);
    chk("hold ready", {31'd0, ex_ready}, 32'd0);
    tick();
    chk("hold no we", {31'd0, we}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BADF00D;
    tick();
    mem_rvalid = 1'b0;
    chk("hold ld we", {31'd0, we}, 32'd1);
    chk("hold ld waddr", {27'd0, waddr}, 32'd20);
    chk("hold ld wdata", wdata, 32'h0BADF00D);
    tick();
    ex_valid = 1'b0;
    chk("hold op we", {31'd0, we}, 32'd1);
    chk("hold op waddr", {27'd0, waddr}, 32'd21);
    chk("hold op wdata", wdata, 32'hCAFEF00D);
    tick();
    chk("hold end", {31'd0, we}, 32'd0);
    chk("err still clear", {31'd0, err_unexp}, 32'd0);

    // Unexpected response in IDLE: sticky error, no write.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55555555;
    tick();
    mem_rvalid = 1'b0;
    chk("unexp err", {31'd0, err_unexp}, 32'd1);
    chk("unexp we", {31'd0, we}, 32'd0);
    tick();
    tick();
    chk("unexp sticky", {31'd0, err_unexp}, 32'd1);

    // Reset mid-load drops the load; a late response is unexpected.
    ex_valid      = 1'b1;
    ex_is_load    = 1'b1;
    ex_wreg       = 1'b1;
    ex_wd         = 5'd15;
    ex_ld_funct3  = 3'b010;
    tick();
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
    chk("pre-rst busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst err", {31'd0, err_unexp}, 32'd0);
    chk("mid rst wdata", wdata, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77777777;
    tick();
    mem_rvalid = 1'b0;
    chk("late rsp we", {31'd0, we}, 32'd0);
    chk("late rsp err", {31'd0, err_unexp}, 32'd1);

    // Response coincident with a load accept: error, load still entered.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex_valid      = 1'b1;
    ex_is_load    = 1'b1;
    ex_wreg       = 1'b1;
    ex_wd         = 5'd3;
    ex_ld_funct3  = 3'b100;
    ex_ld_byteoff = 2'b11;
    mem_rvalid    = 1'b1;
    mem_rdata     = 32'h99999999;
    tick();
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
    mem_rvalid = 1'b0;
    chk("coinc err", {31'd0, err_unexp}, 32'd1);
    chk("coinc busy", {31'd0, busy}, 32'd1);
    chk("coinc we", {31'd0, we}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5000000;
    tick();
    mem_rvalid = 1'b0;
    chk("coinc ld we", {31'd0, we}, 32'd1);
    chk("coinc ld wdata", wdata, 32'h000000A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage RV32I pipeline; the producer end of the register file write port (we/waddr/wdata).
- Accepts retired results from the MEM stage, waits for load data from the memory controller, aligns and extends it, then drives exactly one registered write pulse per instruction.
- Sits between the MEM stage/memory controller and the register file.

Parameters:
- ADDR_W, 5, register address width (RegNumLog2).
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ex_valid  in  1  MEM stage presents an instruction this cycle.
- ex_ready  out  1  block accepts an instruction this cycle.
- ex_wreg  in  1  instruction writes rd.
- ex_wd  in  ADDR_W  destination register rd.
- ex_wdata  in  DATA_W  non-load result.
- ex_is_load  in  1  instruction is a load.
- ex_ld_funct3  in  3  load funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- ex_ld_byteoff  in  2  load address bits [1:0].
- mem_rvalid  in  1  load data valid, single-cycle pulse.
- mem_rdata  in  DATA_W  load data word.
- we  out  1  register file write enable.
- waddr  out  ADDR_W  register file write address.
- wdata  out  DATA_W  register file write data.
- busy  out  1  a load is outstanding.
- err_unexp  out  1  sticky: mem_rvalid arrived while no load was outstanding.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; we=0, waddr=0, wdata=0, busy=0, err_unexp=0. Reset takes effect mid-load: the pending load is dropped and no write is issued for it.
- State IDLE:
  - ex_ready=1.
  - An accept is ex_valid&ex_ready.
  - Accept of a non-load: at the next posedge set we=ex_wreg&(ex_wd!=0), waddr=ex_wd, wdata=ex_wdata. Latency is 1 cycle.
  - Accept of a load: capture rd, wreg, funct3 and byteoff; go to WAIT_LOAD; no write this cycle.
- State WAIT_LOAD:
  - ex_ready=0 and busy=1.
  - When mem_rvalid=1: at the next posedge drive we=wreg&(rd!=0), waddr=rd, wdata=align(mem_rdata), and return to IDLE.
  - Latency is 1 cycle after the response. ex_ready=1 again in the following cycle.
- we is a one-cycle pulse. With no new completion it drops to 0; waddr and wdata hold their last values.
- rd=x0 never produces we=1.
- Back-to-back non-loads: one write per cycle, with no bubbles.
- mem_rvalid in IDLE: ignored and sets err_unexp; only rst clears it.
- mem_rvalid coincident with a load accept in IDLE: this is the unexpected case above; the new load still enters WAIT_LOAD.
- align, using byteoff b:
  - LB/LBU take byte mem_rdata[8b+7:8b], sign- or zero-extended respectively.
  - LH/LHU take the halfword at b[1] (bits [15:0] or [31:16]) and ignore b[0], sign- or zero-extended respectively.
  - LW takes the full word and ignores b.
  - Undefined funct3 (011, 110, 111) is treated as LW.
- ex_valid while ex_ready=0: the instruction is not accepted and the MEM stage holds it.

Decomposition:
- Shared defines header holds RstEnable, WriteEnable, ZeroWord, RegAddrBus, RegBus, RegNumLog2, the load funct3 codes, and state encodings WB_IDLE/WB_WAIT_LOAD.
- One natural sub-module: load_align, purely combinational (funct3, byteoff, rdata -> aligned data). It is reused by the MEM stage for forwarding checks.

Test Plan:
- Reset then a non-load: ex_valid=1, wreg=1, wd=5, wdata=0xDEADBEEF -> next cycle we=1, waddr=5, wdata=0xDEADBEEF; cycle after that we=0.
- LB, byteoff=2, mem_rvalid 3 cycles later with rdata=0x12F45678 -> busy=1 and ex_ready=0 for 3 cycles; one cycle after mem_rvalid we=1, wdata=0xFFFFFFF4. Repeat as LBU -> wdata=0x000000F4.
- LH, byteoff=3 with rdata=0x8001ABCD -> wdata=0xFFFF8001. LHU, byteoff=0 -> wdata=0x0000ABCD. LW, byteoff=1 -> wdata=0x8001ABCD.
- Non-load with wd=0, wdata=0x1 -> we stays 0. Load to x0 completes -> we stays 0, busy clears.
- mem_rvalid=1 in IDLE -> err_unexp=1 and stays 1 until rst, with no write. rst asserted during WAIT_LOAD, then mem_rvalid -> no write, err_unexp=1.
- Four back-to-back non-loads to x1..x4 -> four consecutive we pulses with matching addresses; a load followed immediately by a non-load -> the non-load is held until the load write completes, then writes one cycle later.
